// File: rtl/iram_reader_pkg.sv
// -----------------------------------------------------------------------------
// iram_reader_pkg
//   Shared definitions for the input-RAM frame reader.
//   The text macros form the shared header: the system word width
//   (WordDataBus), the frame length, the index width and the FSM state
//   encoding. The package wraps them as typed parameters and a state enum
//   for the RTL files.
// -----------------------------------------------------------------------------
`ifndef IRAM_READER_DEFS
`define IRAM_READER_DEFS
`define WordDataBus   32
`define IRAM_WORDS    7
`define IRAM_IDX_W    3
`define IRAM_ST_IDLE  1'b0
`define IRAM_ST_SEND  1'b1
`endif

package iram_reader_pkg;

  localparam int WORD_W_DEF = `WordDataBus;
  localparam int WORDS_DEF  = `IRAM_WORDS;
  localparam int IDX_W      = `IRAM_IDX_W;

  typedef enum logic {
    IDLE = `IRAM_ST_IDLE,
    SEND = `IRAM_ST_SEND
  } state_t;

endpackage

// File: rtl/iram_reader_fsm.sv
// -----------------------------------------------------------------------------
// iram_reader_fsm
//   Control half of the frame reader: state, word index and control pulses.
//   Ports:
//     clk, reset_          clock, asynchronous active-low reset
//     in_rdy               a frame is offered on the data inputs
//     soft_clr             synchronous clear, highest priority
//     out_ready            downstream accepts the current word
//     capture              tells the top level to load the holding register
//     in_ack               pulse in the cycle a frame is captured
//     busy, out_valid      high while a frame is being sent
//     frame_done           pulse in the cycle the last word is accepted
//     overrun              sticky: a frame was offered while busy
//     idx                  index of the word currently offered
// -----------------------------------------------------------------------------
module iram_reader_fsm
  import iram_reader_pkg::*;
#(
  parameter int WORDS = WORDS_DEF
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             in_rdy,
  input  logic             soft_clr,
  input  logic             out_ready,
  output logic             capture,
  output logic             in_ack,
  output logic             busy,
  output logic             out_valid,
  output logic             frame_done,
  output logic             overrun,
  output logic [IDX_W-1:0] idx
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_overrun;

  // The acknowledge pulses are decoded from the current state so that they
  // line up with the cycle in which the handshake happens. reset_ is folded
  // into capture so in_ack stays low while the block is held in reset.
  assign capture    = reset_ && (r_state == IDLE) && in_rdy && !soft_clr;
  assign in_ack     = capture;
  assign frame_done = (r_state == SEND) && out_ready && !soft_clr && (r_idx == LAST);
  assign busy       = (r_state == SEND);
  assign out_valid  = (r_state == SEND);
  assign overrun    = r_overrun;
  assign idx        = r_idx;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_overrun <= 1'b0;
    end else if (soft_clr) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_overrun <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_rdy) begin
            r_state <= SEND;
            r_idx   <= '0;
          end
        end
        SEND: begin
          // A new frame cannot be taken mid-send; remember that one was lost.
          if (in_rdy) r_overrun <= 1'b1;
          if (out_ready) begin
            if (r_idx == LAST) begin
              r_state <= IDLE;
              r_idx   <= '0;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/iram_reader.sv
// -----------------------------------------------------------------------------
// iram_reader
//   Captures a parallel frame of WORDS words from the input RAM and streams it
//   out one word per accepted handshake.
//   Ports:
//     clk, reset_            clock, asynchronous active-low reset
//     data_in_0..data_in_6   frame words
//     in_rdy / in_ack        frame offered / frame captured (pulse)
//     soft_clr               synchronous clear from the input RAM
//     busy                   a captured frame is still draining
//     out_data, out_idx      current word and its index
//     out_valid / out_ready  output handshake
//     frame_done             last word accepted (pulse)
//     overrun                sticky: frame offered while busy
// -----------------------------------------------------------------------------
module iram_reader
  import iram_reader_pkg::*;
#(
  parameter int WORDS  = WORDS_DEF,
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic [WORD_W-1:0] data_in_0,
  input  logic [WORD_W-1:0] data_in_1,
  input  logic [WORD_W-1:0] data_in_2,
  input  logic [WORD_W-1:0] data_in_3,
  input  logic [WORD_W-1:0] data_in_4,
  input  logic [WORD_W-1:0] data_in_5,
  input  logic [WORD_W-1:0] data_in_6,
  input  logic              in_rdy,
  input  logic              soft_clr,
  output logic              in_ack,
  output logic              busy,
  output logic [WORD_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_done,
  output logic              overrun
);

  logic [WORD_W-1:0] w_in [7];
  logic [WORD_W-1:0] r_hold [WORDS];
  logic              w_capture;
  logic [IDX_W-1:0]  w_idx;

  assign w_in[0] = data_in_0;
  assign w_in[1] = data_in_1;
  assign w_in[2] = data_in_2;
  assign w_in[3] = data_in_3;
  assign w_in[4] = data_in_4;
  assign w_in[5] = data_in_5;
  assign w_in[6] = data_in_6;

  iram_reader_fsm #(
    .WORDS (WORDS)
  ) u_fsm (
    .clk        (clk),
    .reset_     (reset_),
    .in_rdy     (in_rdy),
    .soft_clr   (soft_clr),
    .out_ready  (out_ready),
    .capture    (w_capture),
    .in_ack     (in_ack),
    .busy       (busy),
    .out_valid  (out_valid),
    .frame_done (frame_done),
    .overrun    (overrun),
    .idx        (w_idx)
  );

  // NOTE: the holding register is a small register file, not a RAM, so it
  // takes the asynchronous reset; out_data must read zero while in reset.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < WORDS; i++) r_hold[i] <= '0;
    end else if (w_capture) begin
      for (int i = 0; i < WORDS; i++) r_hold[i] <= w_in[i];
    end
  end

  // NOTE: out_data gets a default before the select loop so the mux can
  // never infer a latch for an index that matches no entry.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (w_idx == IDX_W'(i)) out_data = r_hold[i];
    end
  end

  assign out_idx = w_idx;

endmodule

// File: tb/tb_iram_reader.sv
module tb_iram_reader;

  localparam int WORDS = 7;
  localparam int WW    = 32;

  logic          clk = 1'b0;
  logic          reset_;
  logic          in_rdy, soft_clr, out_ready;
  logic [WW-1:0] d [7];
  logic          in_ack, busy, out_valid, frame_done, overrun;
  logic [WW-1:0] out_data;
  logic [2:0]    out_idx;

  int total = 0;
  int bad   = 0;

  // Reference model: the words still to be sent, oldest first.
  logic [WW-1:0] q [$];
  bit            m_ovr = 1'b0;
  bit            run_cmp = 1'b0;

  always #5 clk = ~clk;

  iram_reader dut (
    .clk        (clk),
    .reset_     (reset_),
    .data_in_0  (d[0]),
    .data_in_1  (d[1]),
    .data_in_2  (d[2]),
    .data_in_3  (d[3]),
    .data_in_4  (d[4]),
    .data_in_5  (d[5]),
    .data_in_6  (d[6]),
    .in_rdy     (in_rdy),
    .soft_clr   (soft_clr),
    .in_ack     (in_ack),
    .busy       (busy),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model update on each clock edge (and asynchronously on reset).
  task automatic model_step();
    if (!reset_ || soft_clr) begin
      q.delete();
      m_ovr = 1'b0;
    end else if (q.size() != 0) begin
      if (in_rdy) m_ovr = 1'b1;
      if (out_ready) void'(q.pop_front());
    end else if (in_rdy) begin
      for (int i = 0; i < WORDS; i++) q.push_back(d[i]);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset_);
    model_step();
  end

  task automatic compare();
    bit         act;
    logic [2:0] eidx;
    if (!reset_) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_idx", out_idx, 0);
      check("rst_overrun", overrun, 0);
      check("rst_in_ack", in_ack, 0);
      check("rst_frame_done", frame_done, 0);
      return;
    end
    act  = (q.size() != 0);
    eidx = act ? 3'(WORDS - q.size()) : 3'd0;
    check("out_valid", out_valid, act);
    check("busy", busy, act);
    check("out_idx", out_idx, eidx);
    if (act) check("out_data", out_data, q[0]);
    check("in_ack", in_ack, !act && in_rdy && !soft_clr);
    check("frame_done", frame_done, act && out_ready && !soft_clr && q.size() == 1);
    check("overrun", overrun, m_ovr);
  endtask

  initial forever begin
    @(negedge clk);
    if (run_cmp) compare();
  end

  task automatic load_frame(input logic [WW-1:0] base);
    for (int i = 0; i < WORDS; i++) d[i] = base + WW'(i);
  endtask

  task automatic wait_idx(input int v);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (out_valid && out_idx == 3'(v)) return;
      tick();
    end
    check("wait_idx_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (!busy) begin
        tick();
        return;
      end
      tick();
    end
    check("wait_idle_timeout", 0, 1);
  endtask

  initial begin
    int n;
    int last_ack;
    int acks;
    reset_ = 1'b0; in_rdy = 1'b0; soft_clr = 1'b0; out_ready = 1'b1;
    load_frame(0);
    #1 run_cmp = 1'b1;
    tick(); tick();
    check("reset_valid", out_valid, 0);
    check("reset_data", out_data, 0);
    reset_ = 1'b1;
    tick();

    // Single frame 1..7, out_ready held high.
    load_frame(1);
    in_rdy = 1'b1;
    @(negedge clk);
    check("c1_in_ack", in_ack, 1);
    check("c1_out_valid", out_valid, 0);
    tick();
    in_rdy = 1'b0;
    for (int k = 0; k < WORDS; k++) begin
      @(negedge clk);
      check("seq_valid", out_valid, 1);
      check("seq_data", out_data, 64'(k + 1));
      check("seq_idx", out_idx, 64'(k));
      check("seq_done", frame_done, (k == WORDS - 1));
      tick();
    end
    @(negedge clk);
    check("c9_busy", busy, 0);
    check("c9_valid", out_valid, 0);
    tick();

    // out_ready toggling 1,0,1,0...
    load_frame(1);
    in_rdy = 1'b1;
    tick();
    in_rdy = 1'b0;
    n = 0;
    for (int c = 0; c < 40; c++) begin
      out_ready = (c % 2 == 0);
      @(negedge clk);
      if (out_valid && out_ready) begin
        check("tog_data", out_data, 64'(n + 1));
        n++;
      end
      if (frame_done) break;
      tick();
    end
    check("tog_xfers", n, 7);
    tick();
    out_ready = 1'b1;
    wait_idle();

    // Second frame offered mid-send: ignored, overrun set.
    load_frame(1);
    in_rdy = 1'b1;
    tick();
    in_rdy = 1'b0;
    tick(); tick();
    load_frame(8);
    in_rdy = 1'b1;
    @(negedge clk);
    check("ovr_no_ack", in_ack, 0);
    tick();
    in_rdy = 1'b0;
    @(negedge clk);
    check("ovr_flag", overrun, 1);
    check("ovr_data_kept", out_data, 4);
    wait_idle();
    check("ovr_sticky", overrun, 1);

    // soft_clr at index 3.
    load_frame(32'h100);
    in_rdy = 1'b1;
    tick();
    in_rdy = 1'b0;
    wait_idx(2);
    tick();
    soft_clr = 1'b1;
    @(negedge clk);
    check("clr_idx", out_idx, 3);
    check("clr_no_done", frame_done, 0);
    tick();
    soft_clr = 1'b0;
    @(negedge clk);
    check("clr_valid", out_valid, 0);
    check("clr_busy", busy, 0);
    check("clr_overrun", overrun, 0);
    tick();
    load_frame(32'h200);
    in_rdy = 1'b1;
    tick();
    in_rdy = 1'b0;
    @(negedge clk);
    check("clr_new_idx", out_idx, 0);
    check("clr_new_data", out_data, 32'h200);
    wait_idle();

    // Asynchronous reset at index 4.
    load_frame(32'h300);
    in_rdy = 1'b1;
    tick();
    in_rdy = 1'b0;
    wait_idx(3);
    tick();
    reset_ = 1'b0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    check("arst_idx", out_idx, 0);
    check("arst_busy", busy, 0);
    tick(); tick();
    reset_ = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("post_rst_valid", out_valid, 0);
      tick();
    end

    // in_rdy held high: one capture every 8 cycles.
    load_frame(32'h400);
    in_rdy = 1'b1;
    last_ack = -1;
    acks = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (in_ack) begin
        if (last_ack >= 0) check("b2b_period", c - last_ack, 8);
        last_ack = c;
        acks++;
      end
      tick();
    end
    check("b2b_count", acks, 5);
    in_rdy = 1'b0;
    soft_clr = 1'b1;
    tick();
    soft_clr = 1'b0;
    tick();

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < WORDS; i++) d[i] = $urandom;
      in_rdy    = ($urandom_range(3) == 0);
      out_ready = ($urandom_range(2) != 0);
      soft_clr  = ($urandom_range(63) == 0);
      reset_    = ($urandom_range(699) != 0);
      tick();
    end
    reset_ = 1'b1;
    in_rdy = 1'b0;
    soft_clr = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
